// File: rtl/counter_updown_param.sv
// Purpose : parametrised modulo up/down counter with parallel load, terminal count and wrap pulse.
// Latency : one clock from set/enable to q; tc is combinational on q and up; wrap/sat are registered.
// Backpr. : none; every enabled edge advances, set always wins over enable.
//
// Ports:
//   clock  - single clock, rising edge
//   reset  - asynchronous active-low reset (q, wrap, sat cleared immediately)
//   set    - synchronous load of d, clamped to MAX; highest priority
//   enable - count enable, ignored while set=1
//   up     - direction, 1 = increment, 0 = decrement
//   d      - load value
//   q      - registered count, always in 0..MAX
//   tc     - terminal count: up ? (q==MAX) : (q==0)
//   wrap   - one-cycle pulse after q rolls over at either bound
//   sat    - one-cycle pulse after a count is blocked at a bound (saturating build only)
//
// Build option: define COUNTER_SAT_EN to saturate at the bounds instead of wrapping.
// In that build wrap is constant 0; in the default build sat is constant 0.

module counter_updown_param #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned MAX   = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             set,
    input  logic             enable,
    input  logic             up,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             sat
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] q_nxt;
    logic             wrap_nxt;
    logic             sat_nxt;
    logic             at_max;
    logic             at_zero;

    assign at_max  = (q == MAX_V);
    assign at_zero = (q == '0);

    // Terminal count follows the current direction, so it is valid even while enable=0.
    assign tc = up ? at_max : at_zero;

    // Next-state: q never exceeds MAX, so q+1 below MAX and q-1 above 0 cannot overflow WIDTH.
    always_comb begin
        q_nxt    = q;
        wrap_nxt = 1'b0;
        sat_nxt  = 1'b0;
        if (set) begin
            q_nxt = (d > MAX_V) ? MAX_V : d;
        end else if (enable) begin
            if (up) begin
                if (!at_max) begin
                    q_nxt = q + WIDTH'(1);
                end else begin
`ifdef COUNTER_SAT_EN
                    sat_nxt  = 1'b1;
`else
                    q_nxt    = '0;
                    wrap_nxt = 1'b1;
`endif
                end
            end else begin
                if (!at_zero) begin
                    q_nxt = q - WIDTH'(1);
                end else begin
`ifdef COUNTER_SAT_EN
                    sat_nxt  = 1'b1;
`else
                    q_nxt    = MAX_V;
                    wrap_nxt = 1'b1;
`endif
                end
            end
        end
    end

    // Pulses are recomputed every edge, so they last exactly one cycle and
    // repeat back-to-back when consecutive edges each hit a bound.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q    <= '0;
            wrap <= 1'b0;
            sat  <= 1'b0;
        end else begin
            q    <= q_nxt;
            wrap <= wrap_nxt;
            sat  <= sat_nxt;
        end
    end

endmodule

// File: tb/tb_counter_updown_param.sv
module tb_counter_updown_param;

    localparam int W = 4;
    localparam int M = 9;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         set = 1'b0;
    logic         enable = 1'b0;
    logic         up = 1'b0;
    logic [W-1:0] d = '0;
    logic [W-1:0] q;
    logic         tc;
    logic         wrap;
    logic         sat;

    int checks = 0;
    int errors = 0;

    // Reference state: plain integer count plus the pulses expected after the last edge.
    int mq = 0;
    int mw = 0;
    int ms = 0;

    counter_updown_param #(.WIDTH(W), .MAX(M)) dut (
        .clock  (clock),
        .reset  (reset),
        .set    (set),
        .enable (enable),
        .up     (up),
        .d      (d),
        .q      (q),
        .tc     (tc),
        .wrap   (wrap),
        .sat    (sat)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Modulo-(M+1) arithmetic on the abstract count; saturating build holds at the bounds.
    task automatic model_step();
        int nxt;
        mw = 0;
        ms = 0;
        if (set) begin
            mq = (int'(d) > M) ? M : int'(d);
        end else if (enable) begin
            nxt = up ? (mq + 1) % (M + 1) : (mq + M) % (M + 1);
            if ((up && mq == M) || (!up && mq == 0)) begin
`ifdef COUNTER_SAT_EN
                ms = 1;
                nxt = mq;
`else
                mw = 1;
`endif
            end
            mq = nxt;
        end
    endtask

    task automatic compare(input string tag);
        check({tag, ".q"},    32'(q),    32'(mq));
        check({tag, ".wrap"}, 32'(wrap), 32'(mw));
        check({tag, ".sat"},  32'(sat),  32'(ms));
        check({tag, ".tc"},   32'(tc),   32'(up ? (mq == M) : (mq == 0)));
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clock);
        #1;
        compare(tag);
    endtask

    task automatic load(input int v);
        set = 1'b1;
        d = W'(v);
        tick("load");
        set = 1'b0;
    endtask

    initial begin
        // Reset state, checked while reset is held low.
        #3;
        compare("reset");
        @(posedge clock);
        #1;
        compare("reset_hold");
        reset = 1'b1;

        // Up wrap from 0 over 10 clocks.
        enable = 1'b1;
        up = 1'b1;
        for (int i = 0; i < 10; i++) tick("upwrap");
`ifndef COUNTER_SAT_EN
        check("upwrap_end.q", 32'(q), 32'd0);
        check("upwrap_end.wrap", 32'(wrap), 32'd1);
`endif

        // Down wrap from 0.
        up = 1'b0;
        for (int i = 0; i < 3; i++) tick("downwrap");

        // Load priority over enable, and clamping.
        enable = 1'b1;
        up = 1'b1;
        load(5);
        check("load5", 32'(q), 32'd5);
        set = 1'b1;
        d = W'(13);
        tick("load13");
        check("load13_clamp", 32'(q), 32'd9);
        set = 1'b0;

        // Hold at 4, then toggle direction every cycle.
        load(4);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) tick("hold");
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            up = (i % 2 == 0);
            tick("toggle");
        end
        check("toggle_end", 32'(q), 32'd4);

        // Upper bound from 8: saturates with the macro, wraps without.
        up = 1'b1;
        load(8);
        for (int i = 0; i < 3; i++) tick("bound");

        // Asynchronous reset mid-count at q=6, between edges.
        load(5);
        tick("to6");
        check("at6", 32'(q), 32'd6);
        #3;
        reset = 1'b0;
        mq = 0; mw = 0; ms = 0;
        #1;
        compare("async_rst");
        @(posedge clock);
        #1;
        compare("rst_low_edge");
        #2;
        reset = 1'b1;
        #1;
        compare("rst_release");
        tick("post_rst");

        // Randomized stimulus against the reference model.
        for (int i = 0; i < 400; i++) begin
            set = ($urandom_range(0, 9) == 0);
            enable = ($urandom_range(0, 3) != 0);
            up = $urandom_range(0, 1) == 1;
            d = W'($urandom_range(0, 15));
            tick("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
